// File: rtl/cnt2_seq_monitor_if.sv
// cnt2_seq_monitor_if
//   Bundles the sampled counter state and the monitor's status outputs.
//   master : the counter side (drives Q1/Q0, observes status)
//   slave  : the monitor side (observes Q1/Q0, drives status)
//   Signals:
//     Q1, Q0    counter state bits (registered counter outputs)
//     wrap      one-cycle pulse per legal 11->00 step
//     wraps     saturating count of legal wraps since reset
//     done      level, high once wraps reached the target
//     err       sticky illegal-transition flag
//     err_prev  state before the first illegal step
//     err_cur   offending state of the first illegal step
interface cnt2_seq_monitor_if #(
   parameter int WRAP_W = 8
);
   logic              Q1;
   logic              Q0;
   logic              wrap;
   logic [WRAP_W-1:0] wraps;
   logic              done;
   logic              err;
   logic [1:0]        err_prev;
   logic [1:0]        err_cur;

   modport master (
      output Q1, Q0,
      input  wrap, wraps, done, err, err_prev, err_cur
   );

   modport slave (
      input  Q1, Q0,
      output wrap, wraps, done, err, err_prev, err_cur
   );
endinterface

// File: rtl/cnt2_seq_monitor.sv
// cnt2_seq_monitor
//   Watches the state of a 2-bit up-counter (RE forces it to 01) and checks
//   that every clock advances it by exactly one. Counts legal wraps
//   (11->00), flags reaching a programmable wrap target, and latches the
//   first illegal transition until the next reset.
//   Ports:
//     clk  rising-edge clock shared with the counter
//     RE   synchronous active-high reset shared with the counter
//     mon  slave side of cnt2_seq_monitor_if (Q1/Q0 in, status out)
//   All outputs are registered: one clock from sampled state to output.
module cnt2_seq_monitor #(
   parameter int          WRAP_W = 8,
   parameter int unsigned TARGET = 10
) (
   input  logic                clk,
   input  logic                RE,
   cnt2_seq_monitor_if.slave   mon
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [WRAP_W-1:0] TARGET_W = WRAP_W'(TARGET);

   state_t            state_reg;
   logic [1:0]        prev_reg;
   logic              wrap_reg;
   logic [WRAP_W-1:0] wraps_reg;
   logic              done_reg;
   logic              err_reg;
   logic [1:0]        err_prev_reg;
   logic [1:0]        err_cur_reg;

   logic [1:0]        q;
   logic [1:0]        q_exp;
   logic [WRAP_W-1:0] wraps_next;

   assign q     = {mon.Q1, mon.Q0};
   assign q_exp = prev_reg + 2'd1;

   // Saturating increment: once all ones, the count stays there.
   always_comb begin
      wraps_next = wraps_reg;
      if (!(&wraps_reg)) begin
         wraps_next = wraps_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (RE) begin
         state_reg    <= SYNC;
         prev_reg     <= 2'b00;
         wrap_reg     <= 1'b0;
         wraps_reg    <= '0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_prev_reg <= 2'b00;
         err_cur_reg  <= 2'b00;
      end else begin
         wrap_reg <= 1'b0;
         case (state_reg)
            // The counter was forced to 01 on the last reset edge.
            SYNC: begin
               if (q == 2'b01) begin
                  prev_reg  <= q;
                  state_reg <= RUN;
               end else begin
                  err_reg      <= 1'b1;
                  err_prev_reg <= 2'b01;
                  err_cur_reg  <= q;
                  state_reg    <= FAULT;
               end
            end

            // No enable on the counter: every edge must advance by one.
            RUN: begin
               if (q == q_exp) begin
                  prev_reg <= q;
                  if (prev_reg == 2'b11) begin
                     wrap_reg  <= 1'b1;
                     wraps_reg <= wraps_next;
                     if (wraps_next == TARGET_W) begin
                        done_reg <= 1'b1;
                     end
                  end
               end else begin
                  err_reg      <= 1'b1;
                  err_prev_reg <= prev_reg;
                  err_cur_reg  <= q;
                  state_reg    <= FAULT;
               end
            end

            // Everything frozen; only RE leaves this state.
            FAULT: begin
               state_reg <= FAULT;
            end

            default: begin
               state_reg <= SYNC;
            end
         endcase
      end
   end

   assign mon.wrap     = wrap_reg;
   assign mon.wraps    = wraps_reg;
   assign mon.done     = done_reg;
   assign mon.err      = err_reg;
   assign mon.err_prev = err_prev_reg;
   assign mon.err_cur  = err_cur_reg;

endmodule
